ref_win_fetch_ctrl: RTL and testbench

//  Sequences reads of the reference-frame byte memory to fetch one motion-estimation search window.

---
 rtl/me_pkg.sv | 30 +++
 rtl/ref_win_addr_gen.sv | 67 ++++++
 rtl/ref_win_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_ref_win_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the reference-window fetch controller.
// Holds the default frame/window geometry, the FSM state encoding and the
// signed clamp helper used to keep the window inside the frame.
package me_pkg;

    localparam int FRAME_W    = 1920;
    localparam int FRAME_H    = 1080;
    localparam int WIN_W      = 48;
    localparam int WIN_H      = 48;
    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        FETCH  = 2'd2,
        FINISH = 2'd3
    } fetch_state_t;

    // Signed clamp of a 16-bit coordinate into [lo, hi].
    function automatic logic signed [15:0] clamp_s16(
        input logic signed [15:0] v,
        input logic signed [15:0] lo,
        input logic signed [15:0] hi
    );
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/ref_win_addr_gen.sv
// Address generator for one search-window fetch.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_load            capture row base / x offset, zero the row/col counters
//   i_advance         step to the next word (row-major)
//   i_row_base        byte address of the first window row
//   i_cx              clamped window x offset in bytes
//   o_addr            byte address of the current word
//   o_row, o_col      current row / word-in-row indices
//   o_last            current word is the final word of the window
module ref_win_addr_gen
    import me_pkg::*;
#(
    parameter int FRAME_W = me_pkg::FRAME_W,
    parameter int WIN_W   = me_pkg::WIN_W,
    parameter int WIN_H   = me_pkg::WIN_H
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_row_base,
    input  logic [15:0] i_cx,
    output logic [31:0] o_addr,
    output logic [7:0]  o_row,
    output logic [7:0]  o_col,
    output logic        o_last
);
    localparam int COLS = WIN_W / WORD_BYTES;

    logic [31:0] r_row_base;
    logic [15:0] r_cx;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic        w_col_last;

    assign w_col_last = (r_col == 8'(COLS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row_base <= '0;
            r_cx       <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else if (i_load) begin
            r_row_base <= i_row_base;
            r_cx       <= i_cx;
            r_row      <= '0;
            r_col      <= '0;
        end else if (i_advance) begin
            if (w_col_last) begin
                // Row step is an add of the pitch; no multiply per row.
                r_col      <= '0;
                r_row      <= r_row + 8'd1;
                r_row_base <= r_row_base + 32'(FRAME_W);
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    assign o_addr = r_row_base + {16'd0, r_cx} + 32'(r_col) * 32'(WORD_BYTES);
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_last && (r_row == 8'(WIN_H - 1));

endmodule

// File: rtl/ref_win_fetch_ctrl.sv
// Fetches one motion-estimation search window from the reference frame
// memory and streams it row-major on a valid/ready interface.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start, i_abort      start pulse (IDLE only), abort (wins over all)
//   i_win_x, i_win_y      signed window origin, sampled on accepted start
//   o_mem_en, o_mem_addr  memory read request (addr 0 when not enabled)
//   i_mem_data            combinational read data, same cycle as request
//   o_out_valid/i_out_ready, o_out_data/row/col/last   output stream
//   o_busy, o_done        activity flag, 1-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// SETUP  | clamp origin, compute first row base
// FETCH  | issuing reads whenever the output slot is free
// FINISH | all reads issued, waiting for the last word to be taken
module ref_win_fetch_ctrl
    import me_pkg::*;
#(
    parameter int          FRAME_W   = me_pkg::FRAME_W,
    parameter int          FRAME_H   = me_pkg::FRAME_H,
    parameter int          WIN_W     = me_pkg::WIN_W,
    parameter int          WIN_H     = me_pkg::WIN_H,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_win_x,
    input  logic [15:0] i_win_y,
    output logic        o_mem_en,
    output logic [31:0] o_mem_addr,
    input  logic [63:0] i_mem_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_out_data,
    output logic [7:0]  o_out_row,
    output logic [7:0]  o_out_col,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_done
);
    fetch_state_t r_state, w_next;

    logic [15:0]        r_win_x, r_win_y;
    logic signed [15:0] w_cx, w_cy;
    logic [31:0]        w_row_base;
    logic [31:0]        w_addr;
    logic [7:0]         w_row, w_col;
    logic               w_last;
    logic               w_issue;
    logic               w_handshake;

    logic               r_out_valid;
    logic [63:0]        r_out_data;
    logic [7:0]         r_out_row, r_out_col;
    logic               r_out_last;
    logic               r_done;

    assign w_cx = clamp_s16(r_win_x, 16'sd0, 16'(FRAME_W - WIN_W));
    assign w_cy = clamp_s16(r_win_y, 16'sd0, 16'(FRAME_H - WIN_H));
    // cy is non-negative after clamping, so zero-extension is safe.
    assign w_row_base  = BASE_ADDR + {16'd0, w_cy} * 32'(FRAME_W);
    assign w_handshake = r_out_valid && i_out_ready;

    ref_win_addr_gen #(
        .FRAME_W (FRAME_W),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (r_state == SETUP),
        .i_advance  (w_issue),
        .i_row_base (w_row_base),
        .i_cx       (w_cx),
        .o_addr     (w_addr),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_start) w_next = SETUP;
                SETUP:   w_next = FETCH;
                FETCH:   if (w_issue && w_last) w_next = FINISH;
                FINISH:  if (w_handshake) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        // Issue only while the output slot is empty or being emptied.
        w_issue    = (r_state == FETCH) && !i_abort && (!r_out_valid || i_out_ready);
        o_mem_en   = w_issue;
        o_mem_addr = w_issue ? w_addr : 32'd0;
        o_busy     = (r_state != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == IDLE && i_start && !i_abort) begin
                r_win_x <= i_win_x;
                r_win_y <= i_win_y;
            end
            r_done <= (r_state == FINISH) && w_handshake && !i_abort;
            if (i_abort) begin
                r_out_valid <= 1'b0;
            end else if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_mem_data;
                r_out_row   <= w_row;
                r_out_col   <= w_col;
                r_out_last  <= w_last;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;
    assign o_out_col   = r_out_col;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;

endmodule

// File: tb/tb_ref_win_fetch_ctrl.sv
module tb_ref_win_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] win_x = '0, win_y = '0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_data;
    logic [7:0]  out_row, out_col;
    logic        out_last, busy, done;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_iaddr[$];
    logic [63:0] q_data[$];
    logic [7:0]  q_row[$], q_col[$];
    logic        q_last[$];
    int done_cnt, cyc_last_hs, cyc_done, stall_issue, hold_bad, stall_cycles;
    logic busy_after;
    logic [31:0] ea[8];

    ref_win_fetch_ctrl #(
        .FRAME_W(64), .FRAME_H(32), .WIN_W(16), .WIN_H(4), .BASE_ADDR(32'h100)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_win_x(win_x), .i_win_y(win_y),
        .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_row(out_row), .o_out_col(out_col), .o_out_last(out_last),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdata(input logic [31:0] a);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[63-8*b -: 8] = a[7:0] + 8'(b);
        return d;
    endfunction

    always_comb mem_data = mdata(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; win_x = x; win_y = y; out_ready = 1'b1;
    endtask

    // pat 0: always ready; pat 1: ready every third cycle (1,0,0,...)
    task automatic run_fetch(input int budget, input int pat, input int start_at);
        logic        prev_stall;
        logic [63:0] pd;
        logic [7:0]  pr, pc;
        logic        pl;
        q_iaddr.delete(); q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete();
        done_cnt = 0; cyc_last_hs = -1; cyc_done = -1; stall_issue = 0; hold_bad = 0;
        stall_cycles = 0; busy_after = 1'bx; prev_stall = 1'b0;
        pd = '0; pr = '0; pc = '0; pl = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start = (c == start_at);
            if (c == start_at) begin win_x = 16'd0; win_y = 16'd0; end
            abort = 1'b0;
            out_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            if (prev_stall && (out_data !== pd || out_row !== pr || out_col !== pc || out_last !== pl))
                hold_bad++;
            if (mem_en) begin
                q_iaddr.push_back(mem_addr);
                if (out_valid && !out_ready) stall_issue++;
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_row.push_back(out_row);
                q_col.push_back(out_col);   q_last.push_back(out_last);
                if (out_last && cyc_last_hs < 0) cyc_last_hs = c;
            end
            if (done) begin
                done_cnt++;
                if (cyc_done < 0) cyc_done = c;
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cycles++;
            pd = out_data; pr = out_row; pc = out_col; pl = out_last;
            if (cyc_done >= 0 && c == cyc_done + 1) begin
                busy_after = busy;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_window(input string tn);
        chk({tn, "_nissue"}, 64'(q_iaddr.size()), 64'd8);
        chk({tn, "_nwords"}, 64'(q_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_addr%0d", tn, i), (i < q_iaddr.size()) ? 64'(q_iaddr[i]) : 64'hx, 64'(ea[i]));
            chk($sformatf("%s_data%0d", tn, i), (i < q_data.size()) ? q_data[i] : 64'hx, mdata(ea[i]));
            chk($sformatf("%s_row%0d", tn, i), (i < q_row.size()) ? 64'(q_row[i]) : 64'hx, 64'(i / 2));
            chk($sformatf("%s_col%0d", tn, i), (i < q_col.size()) ? 64'(q_col[i]) : 64'hx, 64'(i % 2));
            chk($sformatf("%s_last%0d", tn, i), (i < q_last.size()) ? 64'(q_last[i]) : 64'hx, 64'(i == 7));
        end
        chk({tn, "_done_gap"}, 64'(cyc_done - cyc_last_hs), 64'd1);
        chk({tn, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tn, "_busy_after"}, 64'(busy_after), 64'd0);
    endtask

    initial begin
        int hs;
        int seen;

        // Reset state
        #1;
        chk("rst_ctrl", {59'd0, busy, mem_en, out_valid, out_last, done}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", out_data, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Test 1: window (8,2), always ready
        pulse_start(16'd8, 16'd2);
        run_fetch(40, 0, -1);
        ea = '{32'h188, 32'h190, 32'h1C8, 32'h1D0, 32'h208, 32'h210, 32'h248, 32'h250};
        check_window("t1");
        chk("t1_first_word", (q_data.size() > 0) ? q_data[0] : 64'hx, 64'h88898A8B8C8D8E8F);

        // Test 2: (-5,40) clamps to (0,28)
        pulse_start(-16'sd5, 16'd40);
        run_fetch(40, 0, -1);
        ea = '{32'h800, 32'h808, 32'h840, 32'h848, 32'h880, 32'h888, 32'h8C0, 32'h8C8};
        check_window("t2");

        // Test 3: (60,0) clamps x to 48, backpressure pattern
        pulse_start(16'd60, 16'd0);
        run_fetch(80, 1, -1);
        ea = '{32'h130, 32'h138, 32'h170, 32'h178, 32'h1B0, 32'h1B8, 32'h1F0, 32'h1F8};
        check_window("t3");
        chk("t3_hold", 64'(hold_bad), 64'd0);
        chk("t3_stall_issue", 64'(stall_issue), 64'd0);
        chk("t3_stalled", 64'(stall_cycles > 0), 64'd1);

        // Test 4: abort after the 3rd handshake
        pulse_start(16'd8, 16'd2);
        hs = 0;
        for (int c = 0; c < 40 && hs < 3; c++) begin
            @(negedge clk); start = 1'b0; out_ready = 1'b1; #1;
            if (out_valid && out_ready) hs++;
        end
        chk("t4_reach_hs3", 64'(hs), 64'd3);
        @(negedge clk); abort = 1'b1; #1;
        chk("t4_abort_mem_en", 64'(mem_en), 64'd0);
        @(negedge clk); abort = 1'b0; #1;
        chk("t4_post_abort", {60'd0, busy, out_valid, mem_en, done}, 64'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (done || busy || mem_en) seen++;
        end
        chk("t4_quiet", 64'(seen), 64'd0);
        pulse_start(16'd0, 16'd0);
        run_fetch(40, 0, -1);
        ea = '{32'h100, 32'h108, 32'h140, 32'h148, 32'h180, 32'h188, 32'h1C0, 32'h1C8};
        check_window("t4");

        // Test 5: start+abort together in IDLE, then start during FETCH
        @(negedge clk); start = 1'b1; abort = 1'b1; win_x = 16'd8; win_y = 16'd2;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            #1; if (busy || mem_en || out_valid || done) seen++;
            @(negedge clk);
        end
        chk("t5_ignored", 64'(seen), 64'd0);
        pulse_start(16'd8, 16'd2);
        run_fetch(40, 0, 4);
        ea = '{32'h188, 32'h190, 32'h1C8, 32'h1D0, 32'h208, 32'h210, 32'h248, 32'h250};
        check_window("t5");

        // Test 6: async reset mid-FETCH
        pulse_start(16'd8, 16'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); start = 1'b0; out_ready = 1'b1;
        end
        #1;
        chk("t6_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", {59'd0, busy, mem_en, out_valid, out_last, done}, 64'd0);
        chk("t6_rst_addr", 64'(mem_addr), 64'd0);
        chk("t6_rst_data", out_data, 64'd0);
        chk("t6_rst_rowcol", {48'd0, out_row, out_col}, 64'd0);
        @(negedge clk); rst = 1'b0;
        pulse_start(16'd8, 16'd2);
        run_fetch(40, 0, -1);
        check_window("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
